rr_arbiter: RTL and testbench

Parametrised round-robin arbiter granting one of N_REQ requesters a shared resource. It succeeds the fixed 4-input NOR "no request" detector in the arbiter path: it keeps the idle detection, widens it to N_REQ inputs, and adds registered one-hot grants, fair rotation and an optional hold-limit preemption timer. It sits between the requesting masters and the shared-resource mux, and drives the mux select directly from `gnt_idx`.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 27 ++
 rtl/rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter state encoding and one-hot to index helper
package arb_pkg;

  // Widest arbiter any variant is allowed to build
  localparam int unsigned ARB_MAX_REQ = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Binary index of a one-hot vector; an all-zero vector maps to 0
  function automatic logic [4:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | 5'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate, lowest-set priority encode, rotate back
module rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] win_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_win;

  // Rotate so ptr becomes bit 0, keep the lowest set bit, rotate it back
  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot     = req_dbl[N_REQ-1:0];
    rot_win = rot & (~rot + N_REQ'(1));
    win_dbl = {rot_win, rot_win} << ptr;
    win     = win_dbl[2*N_REQ-1:N_REQ];
    any     = |req;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant; ARB_HOLD_LIMIT_EN adds hold-limit preemption
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N_REQ    = 4,
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned IDX_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             idle
);

  if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || MAX_HOLD < 1) begin : g_bad_params
    $error("rr_arbiter: N_REQ must be 2..32 and MAX_HOLD at least 1");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [N_REQ-1:0] pick_req;
  logic [N_REQ-1:0] pick_win;
  logic             pick_any;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] win_ptr_next;
  logic             owner_req;
  logic             do_grant;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_expired;
  assign hold_expired = (hold_q >= HOLD_W'(MAX_HOLD - 1));
`endif

  // The owner is masked out so neither a release nor a preemption can re-pick it
  assign pick_req     = req & ~gnt_q;
  assign owner_req    = |(req & gnt_q);
  assign win_idx      = IDX_W'(onehot_to_idx(ARB_MAX_REQ'(pick_win)));
  assign win_ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  // Next-state: grant from idle, hand over on release (no bubble), optional preemption
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    do_grant    = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          do_grant = 1'b1;
        end
      end
      ARB_GRANT: begin
`ifdef ARB_HOLD_LIMIT_EN
        hold_d = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + HOLD_W'(1);
`endif
        if (!owner_req) begin
          if (pick_any) begin
            do_grant = 1'b1;
          end else begin
            state_d     = ARB_IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_d      = '0;
`endif
          end
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_expired && pick_any) begin
          do_grant = 1'b1;
        end
`endif
      end
      default: begin
        state_d     = ARB_IDLE;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
    if (do_grant) begin
      state_d     = ARB_GRANT;
      gnt_d       = pick_win;
      gnt_idx_d   = win_idx;
      gnt_valid_d = 1'b1;
      ptr_d       = win_ptr_next;
`ifdef ARB_HOLD_LIMIT_EN
      hold_d      = '0;
`endif
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign idle      = ~(|req);

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - scoreboard bench for rr_arbiter at N_REQ=4 and N_REQ=5; honours ARB_HOLD_LIMIT_EN
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req4 = '0;
  logic [4:0] req5 = '0;
  logic [3:0] gnt4;
  logic [1:0] gnt_idx4;
  logic       gnt_valid4;
  logic       idle4;
  logic [4:0] gnt5;
  logic [2:0] gnt_idx5;
  logic       gnt_valid5;
  logic       idle5;

  always #5 clk = ~clk;

  rr_arbiter #(.N_REQ(4), .MAX_HOLD(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .req       (req4),
    .gnt       (gnt4),
    .gnt_idx   (gnt_idx4),
    .gnt_valid (gnt_valid4),
    .idle      (idle4)
  );

  rr_arbiter #(.N_REQ(5), .MAX_HOLD(8)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .req       (req5),
    .gnt       (gnt5),
    .gnt_idx   (gnt_idx5),
    .gnt_valid (gnt_valid5),
    .idle      (idle5)
  );

  typedef struct {
    int         step;
    logic       sel5;
    logic [4:0] gnt;
    logic       valid;
    logic [2:0] idx;
    logic       idle;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, step, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; expected values are what the DUT shows during this cycle
  task automatic apply(input logic r, input logic sel5, input logic [4:0] rq,
                       input logic [4:0] eg, input logic [2:0] ei);
    exp_t e;
    rst = r;
    if (sel5) begin
      req5 = rq;
      req4 = '0;
    end else begin
      req4 = rq[3:0];
      req5 = '0;
    end
    e.step  = step_no;
    e.sel5  = sel5;
    e.gnt   = eg;
    e.valid = (eg != 5'b0);
    e.idx   = ei;
    e.idle  = (rq == 5'b0);
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare mid-cycle, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel5) begin
        check("gnt",       e.step, 32'(gnt5),       32'(e.gnt));
        check("gnt_valid", e.step, 32'(gnt_valid5), 32'(e.valid));
        check("gnt_idx",   e.step, 32'(gnt_idx5),   32'(e.idx));
        check("idle",      e.step, 32'(idle5),      32'(e.idle));
      end else begin
        check("gnt",       e.step, 32'(gnt4),       32'(e.gnt));
        check("gnt_valid", e.step, 32'(gnt_valid4), 32'(e.valid));
        check("gnt_idx",   e.step, 32'(gnt_idx4),   32'(e.idx));
        check("idle",      e.step, 32'(idle4),      32'(e.idle));
      end
    end
  end

  initial begin
    rst  = 1'b1;
    req4 = '0;
    req5 = '0;
    @(posedge clk);
    #1;

    // Reset state and idle with no requests
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0);

    // Single requester 2, then drop
    apply(1'b0, 1'b0, 5'b00100, 5'b00000, 3'd0);
    apply(1'b0, 1'b0, 5'b00100, 5'b00100, 3'd2);
    apply(1'b0, 1'b0, 5'b00000, 5'b00100, 3'd2);
    apply(1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0);

    // All request from reset exit; each owner drops for one cycle after one grant
    apply(1'b1, 1'b0, 5'b00000, 5'b00000, 3'd0);
    apply(1'b0, 1'b0, 5'b01111, 5'b00000, 3'd0);
    apply(1'b0, 1'b0, 5'b01110, 5'b00001, 3'd0);
    apply(1'b0, 1'b0, 5'b01101, 5'b00010, 3'd1);
    apply(1'b0, 1'b0, 5'b01011, 5'b00100, 3'd2);
    apply(1'b0, 1'b0, 5'b00111, 5'b01000, 3'd3);
    apply(1'b0, 1'b0, 5'b00000, 5'b00001, 3'd0);
    apply(1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0);

    // Owner 1 holds while requester 3 waits
    apply(1'b0, 1'b0, 5'b00010, 5'b00000, 3'd0);
`ifdef ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 8; i++) apply(1'b0, 1'b0, 5'b01010, 5'b00010, 3'd1);
    apply(1'b0, 1'b0, 5'b00000, 5'b01000, 3'd3);
`else
    for (int i = 0; i < 50; i++) apply(1'b0, 1'b0, 5'b01010, 5'b00010, 3'd1);
    apply(1'b0, 1'b0, 5'b00000, 5'b00010, 3'd1);
`endif
    apply(1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0);

    // Reset while owner 2 holds with every input requesting
    apply(1'b1, 1'b0, 5'b00000, 5'b00000, 3'd0);
    apply(1'b0, 1'b0, 5'b00100, 5'b00000, 3'd0);
    apply(1'b0, 1'b0, 5'b01111, 5'b00100, 3'd2);
    apply(1'b1, 1'b0, 5'b01111, 5'b00100, 3'd2);
    apply(1'b0, 1'b0, 5'b01111, 5'b00000, 3'd0);
    apply(1'b0, 1'b0, 5'b00000, 5'b00001, 3'd0);
    apply(1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0);

    // N_REQ=5 wrap: park ptr at 4, then requests 4 and 0
    apply(1'b1, 1'b1, 5'b00000, 5'b00000, 3'd0);
    apply(1'b0, 1'b1, 5'b01000, 5'b00000, 3'd0);
    apply(1'b0, 1'b1, 5'b00000, 5'b01000, 3'd3);
    apply(1'b0, 1'b1, 5'b10001, 5'b00000, 3'd0);
    apply(1'b0, 1'b1, 5'b10001, 5'b10000, 3'd4);
    apply(1'b0, 1'b1, 5'b00001, 5'b10000, 3'd4);
    apply(1'b0, 1'b1, 5'b00000, 5'b00001, 3'd0);
    apply(1'b0, 1'b1, 5'b00000, 5'b00000, 3'd0);

    @(negedge clk);
    #1;
    check("sb_drain", step_no, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
